conv_col_feeder: RTL and testbench
==================================

# conv_col_feeder

Upstream stage of the convolution engine. Accepts the input image as a stream of 32-bit host words (4 pixels each, row-major), holds the two previous image rows in an internal line buffer, and emits one K_H-pixel vertical column per cycle with a valid/ready handshake. The conv engine's circular image register consumes these columns directly, so the host no longer has to write every column itself.

## Interface

- K_H, 3, kernel height; number of pixels per emitted column
- IN_W, 15, image width in pixels
- IN_H, 16, image height in pixels; IN_H*IN_W must be a multiple of 4
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame from IDLE
- in_valid  in  1  in_data is valid
- in_ready  out  1  word accepted when in_valid && in_ready
- in_data  in  32  pixels p0..p3 in bytes [7:0]..[31:24]; p0 comes first in raster order
- col_valid  out  1  col_data is valid
- col_ready  in  1  column consumed when col_valid && col_ready
- col_data  out  8*K_H  byte k = row y-(K_H-1)+k at column x; byte 0 is the oldest row
- col_x  out  4  x of the emitted column
- col_y  out  4  y of the newest row in the column
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at frame end

## Operation

- Reset values: state IDLE; in_ready, col_valid, busy and frame_done are 0; col_data, col_x and col_y are 0; all counters are 0. Line-buffer contents are not cleared and are don't-care.
- States and transitions:
  - IDLE -> RUN on start. Entering RUN clears the x/y counters, the word counter and the unpacker.
  - RUN -> DRAIN when the last pixel (index IN_H*IN_W-1) is consumed.
  - DRAIN -> DONE when the final column handshake occurs.
  - DONE -> IDLE after one cycle.
  - start is ignored outside IDLE.
- Unpacker: a 4-pixel holding register with a pix_left count.
  - in_ready = RUN && words_accepted < IN_H*IN_W/4 && (pix_left==0 || (pix_left==1 && pix_adv)).
  - On acceptance, pix_left is set to 4.
- Pixel advance (pix_adv): pix_left>0 && (!col_valid || col_ready). One pixel is consumed per advance.
- Line buffer: K_H-1 rows of IN_W bytes. For each consumed pixel at (x,y), row[k][x] is shifted toward older rows and the new pixel is written to the newest row.
- Column emission: a pixel consumed with y >= K_H-1 loads the column register with {newest pixel, rows...} and sets col_valid. Pixels with y < K_H-1 only fill the line buffer.
- Output hold: col_data, col_x and col_y stay stable while col_valid && !col_ready. col_valid falls after a handshake unless a new column is loaded in the same cycle.
- Columns per frame: (IN_H-K_H+1)*IN_W, which is 210 at the default parameters.
- Counter wrap: x wraps IN_W-1 -> 0 and y then increments. y stops at IN_H-1.
- Excess input: words offered after the frame's IN_H*IN_W/4 words are not accepted (in_ready stays 0).
- Reset mid-frame: returns to IDLE next cycle. A pending column is dropped and frame_done does not pulse.

## Timing

- Column latency: col_valid rises the cycle after the pixel that completes the column is consumed.
- Throughput with col_ready held at 1: one pixel per cycle, no bubbles between words as long as in_valid is continuous. A full frame takes IN_H*IN_W + 2 cycles from start to frame_done.
- Backpressure: col_ready=0 stalls pixel consumption in the same cycle. in_ready deasserts combinationally through pix_adv.
- frame_done: asserted in the DONE cycle, one cycle after the last column handshake. busy falls with it in the following cycle.
- Start latency: in_ready can first rise in the cycle after start.

## Configuration

- CONV_COL_FEEDER_STATS_EN defined:
  - Adds output stall_cnt (16 bits, saturating).
  - stall_cnt counts cycles with col_valid && !col_ready during a frame.
  - It is cleared on start and on rst, and holds its value after frame_done.
- Not defined: the stall_cnt port and its counter are absent; all other behaviour is identical.

## Test plan

- Ramp frame: pixel i = i mod 256, col_ready=1, in_valid continuous.
  - First column: (x=0,y=2), col_data=0x1E0F00.
  - Last column: (x=14,y=15), col_data=0xEFE0D1.
  - Exactly 210 columns; frame_done pulses 242 cycles after start.
- Random backpressure: col_ready random at 50%.
  - Column sequence must match the ramp run.
  - col_data, col_x and col_y are held stable while stalled.
  - No column is lost or duplicated.
- Input gaps: in_valid toggled 1/0 per cycle. Same 210 columns; in_ready is never high while pix_left>1.
- Reset and start handling:
  - rst asserted after 100 pixels: next cycle IDLE, col_valid=0, no frame_done.
  - A fresh start then reproduces the ramp result.
  - A start pulse issued mid-RUN has no effect.
- Excess input: hold in_valid=1 past the 60th word. in_ready stays 0 after 60 acceptances.
- With CONV_COL_FEEDER_STATS_EN: col_ready held low for 7 cycles at the first column gives stall_cnt=7 at frame_done. A second start clears it to 0.

Source files
------------

// File: rtl/conv_col_feeder_if.sv
// Stream bundle for conv_col_feeder: packed pixel words in, K_H-pixel vertical columns out.
// master is the feeder's view; slave is the host/consumer view.
interface conv_col_feeder_if #(
  parameter int K_H = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             col_valid;
  logic             col_ready;
  logic [8*K_H-1:0] col_data;
  logic [3:0]       col_x;
  logic [3:0]       col_y;

  modport master (
    input  in_valid, in_data, col_ready,
    output in_ready, col_valid, col_data, col_x, col_y
  );

  modport slave (
    output in_valid, in_data, col_ready,
    input  in_ready, col_valid, col_data, col_x, col_y
  );
endinterface

// File: rtl/conv_col_feeder.sv
// Unpacks 4-pixel host words, keeps the previous K_H-1 image rows and emits vertical columns.
// Optional macro CONV_COL_FEEDER_STATS_EN adds a saturating stall_cnt output.
module conv_col_feeder #(
  parameter int K_H  = 3,
  parameter int IN_W = 15,
  parameter int IN_H = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  conv_col_feeder_if.master bus,
  output logic busy,
  output logic frame_done
`ifdef CONV_COL_FEEDER_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int DATA_W = 8;
  localparam int NPIX   = IN_H * IN_W;
  localparam int NWORDS = NPIX / 4;
  localparam int WCW    = $clog2(NWORDS + 1);

  localparam logic [3:0]     X_LAST   = 4'(IN_W - 1);
  localparam logic [3:0]     Y_LAST   = 4'(IN_H - 1);
  localparam logic [3:0]     Y_FIRST  = 4'(K_H - 1);
  localparam logic [WCW-1:0] NWORDS_L = WCW'(NWORDS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state;
  logic [31:0]              hold_p0;
  logic [2:0]               pix_left;
  logic [WCW-1:0]           words_acc;
  logic [3:0]               x_cnt;
  logic [3:0]               y_cnt;
  logic [DATA_W-1:0]        lb [K_H-1][IN_W];

  logic                     pix_adv;
  logic                     accept;
  logic                     col_load;
  logic                     last_pix;
  logic [DATA_W-1:0]        pix_p0;
  logic [8*K_H-1:0]         col_next;

`ifdef CONV_COL_FEEDER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign pix_p0 = hold_p0[DATA_W-1:0];

  // A new word may land in the same cycle its predecessor's last pixel leaves.
  assign bus.in_ready = (state == RUN) && (words_acc < NWORDS_L) &&
                        ((pix_left == 3'd0) || ((pix_left == 3'd1) && pix_adv));

  always_comb begin
    pix_adv  = (pix_left != 3'd0) && (!bus.col_valid || bus.col_ready);
    accept   = bus.in_valid && bus.in_ready;
    col_load = pix_adv && (y_cnt >= Y_FIRST);
    last_pix = pix_adv && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    col_next = '0;
    col_next[8*(K_H-1) +: 8] = pix_p0;
    for (int k = 0; k < K_H - 1; k++) begin
      col_next[8*k +: 8] = lb[k][x_cnt];
    end
  end

  // Stage p0: pixel holding register and line buffer (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_p0 <= bus.in_data;
    end else if (pix_adv) begin
      hold_p0 <= {8'h00, hold_p0[31:8]};
    end
    if (pix_adv) begin
      for (int k = 0; k < K_H - 2; k++) begin
        lb[k][x_cnt] <= lb[k+1][x_cnt];
      end
      lb[K_H-2][x_cnt] <= pix_p0;
    end
  end

  // Stage p1: control FSM, counters and the column output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      pix_left      <= 3'd0;
      words_acc     <= '0;
      x_cnt         <= 4'd0;
      y_cnt         <= 4'd0;
      bus.col_valid <= 1'b0;
      bus.col_data  <= '0;
      bus.col_x     <= 4'd0;
      bus.col_y     <= 4'd0;
    end else begin
      if (accept) begin
        pix_left  <= 3'd4;
        words_acc <= words_acc + 1'b1;
      end else if (pix_adv) begin
        pix_left <= pix_left - 3'd1;
      end

      if (pix_adv) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= 4'd0;
          if (y_cnt != Y_LAST) y_cnt <= y_cnt + 4'd1;
        end else begin
          x_cnt <= x_cnt + 4'd1;
        end
      end

      if (col_load) begin
        bus.col_valid <= 1'b1;
        bus.col_data  <= col_next;
        bus.col_x     <= x_cnt;
        bus.col_y     <= y_cnt;
      end else if (bus.col_ready) begin
        bus.col_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            pix_left  <= 3'd0;
            words_acc <= '0;
            x_cnt     <= 4'd0;
            y_cnt     <= 4'd0;
          end
        end
        RUN: begin
          if (last_pix) state <= DRAIN;
        end
        DRAIN: begin
          if (bus.col_valid && bus.col_ready) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_COL_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= 16'd0;
    end else if (busy && bus.col_valid && !bus.col_ready) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_conv_col_feeder.sv
// Bench for conv_col_feeder: ramp frames under several handshake patterns, checked against
// a column list built directly from the image, plus reset/start/excess-input cases.
module tb_conv_col_feeder;
  localparam int K_H    = 3;
  localparam int IN_W   = 15;
  localparam int IN_H   = 16;
  localparam int NPIX   = IN_W * IN_H;
  localparam int NWORDS = NPIX / 4;
  localparam int NCOLS  = (IN_H - K_H + 1) * IN_W;
  localparam int CW     = 8 * K_H + 8;
  localparam int M_RAMP = 0, M_RAND = 1, M_GAPS = 2, M_STALL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done;
`ifdef CONV_COL_FEEDER_STATS_EN
  logic [15:0] stall_cnt;
`endif

  conv_col_feeder_if #(.K_H(K_H)) bus ();

  conv_col_feeder #(.K_H(K_H), .IN_W(IN_W), .IN_H(IN_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef CONV_COL_FEEDER_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t0 = 0;
  int n_acc = 0, n_col = 0, n_stall = 0;
  int mode = M_RAMP;
  bit feed_en = 1'b0, gap_ph = 1'b0, prev_stall = 1'b0;
  logic [31:0]   words [NWORDS];
  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] first_col, last_col, prev_col;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] pix(input int y, input int x);
    return 8'((y * IN_W + x) % 256);
  endfunction

  // Expected columns straight from the image: byte k is row y-(K_H-1)+k.
  function automatic void build_expect();
    logic [8*K_H-1:0] d;
    exp_q.delete();
    for (int y = K_H - 1; y < IN_H; y++) begin
      for (int x = 0; x < IN_W; x++) begin
        for (int k = 0; k < K_H; k++) d[8*k +: 8] = pix(y - (K_H - 1) + k, x);
        exp_q.push_back({4'(x), 4'(y), d});
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus driver: words in raster order, junk once the frame's words are used up.
  always @(posedge clk) begin
    #1;
    gap_ph = ~gap_ph;
    bus.in_valid = feed_en && ((mode != M_GAPS) || gap_ph);
    bus.in_data  = (n_acc < NWORDS) ? words[n_acc] : 32'hA5A5_A5A5;
    case (mode)
      M_RAND:  bus.col_ready = 1'($urandom_range(0, 1));
      M_STALL: bus.col_ready = (n_stall >= 7);
      default: bus.col_ready = 1'b1;
    endcase
  end

  // Compare process: every handshake against the model, holds while stalled, excess input.
  always @(negedge clk) begin
    logic [CW-1:0] got, e;
    got = {bus.col_x, bus.col_y, bus.col_data};
    if (busy && n_acc >= NWORDS) chk("excess_in_ready", bus.in_ready, 0);
    if (bus.in_valid && bus.in_ready) n_acc++;
    if (prev_stall) chk("hold_stable", {bus.col_valid, got}, {1'b1, prev_col});
    if (bus.col_valid && bus.col_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_column: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        chk("column", got, e);
      end
      if (n_col == 0) first_col = got;
      last_col = got;
      n_col++;
    end
    if (busy && bus.col_valid && !bus.col_ready) n_stall++;
    prev_stall = bus.col_valid && !bus.col_ready;
    prev_col   = got;
  end

  task automatic begin_frame(input int m);
    @(negedge clk);
    mode = m;
    build_expect();
    n_acc = 0;
    n_col = 0;
    n_stall = 0;
    feed_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic run_frame(input int m, input int midstart, input bit chk_cycles);
    bit got_done;
    begin_frame(m);
    got_done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
`ifdef CONV_COL_FEEDER_STATS_EN
      if (i == 0) chk("stall_cnt_cleared", stall_cnt, 0);
`endif
      start = (i == midstart);
      if (frame_done) begin
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("frame_done_seen", got_done, 1);
    if (chk_cycles) chk("frame_cycles", cyc - t0, NPIX + 2);
    chk("column_count", n_col, NCOLS);
    chk("queue_empty", exp_q.size(), 0);
    chk("words_accepted", n_acc, NWORDS);
    chk("first_column", first_col, {4'd0, 4'd2, 24'h1E0F00});
    chk("last_column", last_col, {4'd14, 4'd15, 24'hEFE0D1});
    chk("busy_at_done", busy, 1);
`ifdef CONV_COL_FEEDER_STATS_EN
    chk("stall_cnt_model", stall_cnt, n_stall);
    if (m == M_STALL) chk("stall_cnt_seven", stall_cnt, 7);
`endif
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", frame_done, 0);
    feed_en = 1'b0;
  endtask

  initial begin
    bit saw_done;
    for (int w = 0; w < NWORDS; w++) begin
      for (int b = 0; b < 4; b++) words[w][8*b +: 8] = 8'((4 * w + b) % 256);
    end
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_col_valid", bus.col_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_col_data", bus.col_data, 0);
    chk("rst_col_xy", {bus.col_x, bus.col_y}, 0);
    rst = 1'b0;

    run_frame(M_RAMP, -1, 1'b1);
    run_frame(M_RAND, -1, 1'b0);
    run_frame(M_GAPS, -1, 1'b0);

    begin_frame(M_RAMP);
    repeat (101) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_col_valid", bus.col_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    saw_done = frame_done;
    repeat (20) begin
      @(negedge clk);
      if (frame_done) saw_done = 1'b1;
    end
    chk("midrst_no_done", saw_done, 0);
    feed_en = 1'b0;

    run_frame(M_RAMP, 50, 1'b1);
`ifdef CONV_COL_FEEDER_STATS_EN
    run_frame(M_STALL, -1, 1'b0);
    run_frame(M_RAMP, -1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
